// File: rtl/revcnt_ctrl.sv
// revcnt_ctrl: prescaled up/down count sequencer.
// A DIV-cycle prescaler produces one-cycle step strobes. On each strobe the
// bounded count register steps up or down, then wraps or stops at the bound.
// One-cycle commands are resolved by priority: clr > load > stop > start > step.
module revcnt_ctrl #(
    parameter int DIV     = 10_000_000,
    parameter int DIV_W   = 24,
    parameter int CNT_W   = 4,
    parameter int CNT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dir,
    input  logic             wrap_en,
    output logic [CNT_W-1:0] cnt,
    output logic             tick,
    output logic             tc,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] PMAX = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(CNT_MAX);

    state_t           state, state_n;
    logic [DIV_W-1:0] pcnt, pcnt_n;
    logic [CNT_W-1:0] cnt_n;
    logic             tick_n, tc_n;
    logic             at_term;
    logic [CNT_W-1:0] load_sat;

    // Terminal value depends on the current direction; used to gate restart from DONE.
    assign at_term  = dir ? (cnt == CMAX) : (cnt == '0);
    assign load_sat = (load_val > CMAX) ? CMAX : load_val;

    // State, prescaler, count and all output flags update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pcnt    <= '0;
            cnt     <= '0;
            tick    <= 1'b0;
            tc      <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            pcnt    <= pcnt_n;
            cnt     <= cnt_n;
            tick    <= tick_n;
            tc      <= tc_n;
            running <= (state_n == S_RUN);
            done    <= (state_n == S_DONE);
        end
    end

    // Command resolution, prescaler advance and count stepping.
    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        cnt_n   = cnt;
        tick_n  = 1'b0;
        tc_n    = 1'b0;
        if (clr) begin
            cnt_n   = '0;
            pcnt_n  = '0;
            state_n = S_IDLE;
        end else if (load) begin
            cnt_n  = load_sat;
            pcnt_n = '0;
            if (state == S_DONE) state_n = S_IDLE;
        end else if (stop && state == S_RUN) begin
            // Pause freezes the prescaler so resume keeps the phase.
            state_n = S_PAUSE;
        end else if (start && state != S_RUN) begin
            case (state)
                S_IDLE: begin
                    state_n = S_RUN;
                    pcnt_n  = '0;
                end
                S_PAUSE: state_n = S_RUN;
                S_DONE: begin
                    if (!at_term) begin
                        state_n = S_RUN;
                        pcnt_n  = '0;
                    end
                end
                default: state_n = state;
            endcase
        end else if (state == S_RUN) begin
            if (pcnt == PMAX) begin
                pcnt_n = '0;
                tick_n = 1'b1;
                if (dir) begin
                    if (cnt == CMAX) begin
                        tc_n = 1'b1;
                        if (wrap_en) cnt_n = '0;
                        else state_n = S_DONE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    if (cnt == '0) begin
                        tc_n = 1'b1;
                        if (wrap_en) cnt_n = CMAX;
                        else state_n = S_DONE;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end else begin
                pcnt_n = pcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_revcnt_ctrl.sv
// Directed bench for revcnt_ctrl with DIV=4, CNT_MAX=9.
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_revcnt_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, clr, load, dir, wrap_en;
    logic [3:0] load_val;
    logic [3:0] cnt;
    logic       tick, tc, running, done;

    int n_chk  = 0;
    int n_fail = 0;

    revcnt_ctrl #(.DIV(4), .DIV_W(4), .CNT_W(4), .CNT_MAX(9)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
        .load(load), .load_val(load_val), .dir(dir), .wrap_en(wrap_en),
        .cnt(cnt), .tick(tick), .tc(tc), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; stop = 0; clr = 0; load = 0; load_val = 0;
        dir = 1'b1; wrap_en = 1'b1;
        cyc(2);
        n_chk++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", cnt); end
        n_chk++; if ({tick, tc, running, done} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_flags: got %b exp 0000", {tick, tc, running, done}); end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_up_wrap;
        dir = 1'b1; wrap_en = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        n_chk++; if (running !== 1'b1) begin n_fail++; $display("FAIL up_running: got %b exp 1", running); end
        for (int i = 1; i <= 10; i++) begin
            cyc(3);
            n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL up_tick_low step%0d: got %b exp 0", i, tick); end
            cyc(1);
            n_chk++; if (cnt !== ((i == 10) ? 4'd0 : 4'(i))) begin
                n_fail++; $display("FAIL up_cnt step%0d: got %0d exp %0d", i, cnt, (i == 10) ? 0 : i); end
            n_chk++; if ({tick, tc} !== {1'b1, (i == 10)}) begin
                n_fail++; $display("FAIL up_tick_tc step%0d: got %b exp %b", i, {tick, tc}, {1'b1, (i == 10)}); end
        end
        cyc(1);
        n_chk++; if ({tick, tc} !== 2'b00) begin n_fail++; $display("FAIL up_tc_pulse: got %b exp 00", {tick, tc}); end
        clr = 1'b1; cyc(1); clr = 1'b0;
        n_chk++; if ({running, cnt} !== 5'd0) begin n_fail++; $display("FAIL up_clr: got %b exp 0", {running, cnt}); end
    endtask

    task automatic test_down_stop;
        dir = 1'b0; wrap_en = 1'b0; load_val = 4'd2;
        load = 1'b1; cyc(1); load = 1'b0;
        n_chk++; if (cnt !== 4'd2) begin n_fail++; $display("FAIL dn_load: got %0d exp 2", cnt); end
        start = 1'b1; cyc(1); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(4);
            n_chk++; if (cnt !== ((i == 0) ? 4'd1 : 4'd0)) begin
                n_fail++; $display("FAIL dn_cnt step%0d: got %0d exp %0d", i, cnt, (i == 0) ? 1 : 0); end
            n_chk++; if ({tick, tc} !== {1'b1, (i == 2)}) begin
                n_fail++; $display("FAIL dn_tick_tc step%0d: got %b exp %b", i, {tick, tc}, {1'b1, (i == 2)}); end
        end
        n_chk++; if ({running, done} !== 2'b01) begin n_fail++; $display("FAIL dn_done: got %b exp 01", {running, done}); end
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(5);
        n_chk++; if ({running, done, cnt} !== 6'b010000) begin
            n_fail++; $display("FAIL dn_start_ignored: got %b exp 010000", {running, done, cnt}); end
        dir = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        n_chk++; if ({running, done} !== 2'b10) begin n_fail++; $display("FAIL dn_restart: got %b exp 10", {running, done}); end
        cyc(4);
        n_chk++; if ({cnt, tick} !== {4'd1, 1'b1}) begin n_fail++; $display("FAIL dn_restart_step: got %b exp 00011", {cnt, tick}); end
        clr = 1'b1; cyc(1); clr = 1'b0;
    endtask

    task automatic test_pause;
        dir = 1'b1; wrap_en = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        n_chk++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL pa_first: got %0d exp 1", cnt); end
        cyc(2);
        stop = 1'b1; cyc(1); stop = 1'b0;
        n_chk++; if (running !== 1'b0) begin n_fail++; $display("FAIL pa_paused: got %b exp 0", running); end
        cyc(10);
        n_chk++; if ({cnt, tick} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL pa_hold: got %b exp 00010", {cnt, tick}); end
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(1);
        n_chk++; if ({cnt, tick} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL pa_early: got %b exp 00010", {cnt, tick}); end
        cyc(1);
        n_chk++; if ({cnt, tick} !== {4'd2, 1'b1}) begin n_fail++; $display("FAIL pa_phase: got %b exp 00101", {cnt, tick}); end
        // Stop lands on the cycle that would have stepped.
        cyc(3);
        stop = 1'b1; cyc(1); stop = 1'b0;
        n_chk++; if ({cnt, tick, running} !== {4'd2, 2'b00}) begin
            n_fail++; $display("FAIL pa_stop_wins: got %b exp 001000", {cnt, tick, running}); end
        cyc(3);
        start = 1'b1; cyc(1); start = 1'b0;
        n_chk++; if ({cnt, tick} !== {4'd2, 1'b0}) begin n_fail++; $display("FAIL pa_resume0: got %b exp 00100", {cnt, tick}); end
        cyc(1);
        n_chk++; if ({cnt, tick} !== {4'd3, 1'b1}) begin n_fail++; $display("FAIL pa_resume1: got %b exp 00111", {cnt, tick}); end
    endtask

    task automatic test_priority;
        load_val = 4'd5;
        load = 1'b1; cyc(1); load = 1'b0;
        n_chk++; if ({cnt, running} !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL pr_load_run: got %b exp 01011", {cnt, running}); end
        clr = 1'b1; load = 1'b1; start = 1'b1; cyc(1);
        clr = 1'b0; load = 1'b0; start = 1'b0;
        n_chk++; if ({cnt, running, done} !== 6'd0) begin n_fail++; $display("FAIL pr_clr_wins: got %b exp 0", {cnt, running, done}); end
        cyc(6);
        n_chk++; if ({cnt, tick} !== 5'd0) begin n_fail++; $display("FAIL pr_idle_hold: got %b exp 0", {cnt, tick}); end
    endtask

    task automatic test_load_sat;
        load_val = 4'd15;
        load = 1'b1; cyc(1); load = 1'b0;
        n_chk++; if (cnt !== 4'd9) begin n_fail++; $display("FAIL ld_sat: got %0d exp 9", cnt); end
        dir = 1'b1; wrap_en = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        n_chk++; if ({cnt, tc, done} !== {4'd9, 2'b11}) begin n_fail++; $display("FAIL ld_done: got %b exp 100111", {cnt, tc, done}); end
        load_val = 4'd3;
        load = 1'b1; cyc(1); load = 1'b0;
        n_chk++; if ({cnt, running, done} !== {4'd3, 2'b00}) begin
            n_fail++; $display("FAIL ld_from_done: got %b exp 001100", {cnt, running, done}); end
    endtask

    task automatic test_reset_mid;
        load_val = 4'd7; dir = 1'b1; wrap_en = 1'b1;
        load = 1'b1; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(3);
        n_chk++; if ({cnt, running} !== {4'd7, 1'b1}) begin n_fail++; $display("FAIL rm_setup: got %b exp 01111", {cnt, running}); end
        rst = 1'b1; cyc(1);
        n_chk++; if ({cnt, tick, tc, running, done} !== 8'd0) begin
            n_fail++; $display("FAIL rm_reset: got %b exp 0", {cnt, tick, tc, running, done}); end
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        start = 1'b1; cyc(1); start = 1'b0;
        n_chk++; if ({cnt, running} !== 5'd0) begin n_fail++; $display("FAIL rm_rst_start: got %b exp 0", {cnt, running}); end
        rst = 1'b0;
        cyc(6);
        n_chk++; if ({cnt, running, tick} !== 6'd0) begin n_fail++; $display("FAIL rm_after: got %b exp 0", {cnt, running, tick}); end
    endtask

    initial begin
        test_reset;
        test_up_wrap;
        test_down_stop;
        test_pause;
        test_priority;
        test_load_sat;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
